// File: rtl/hpdcache_wbuf_send_sched_if.sv
// hpdcache_wbuf_send_sched_if: write-buffer scheduler command/send/ack bundle.
//   master (directory side): drives cfg, alloc/write/close/flush, send_ready, ack;
//     observes send_valid/send_idx offer and free/busy status.
//   slave (scheduler side): the mirror image.
interface hpdcache_wbuf_send_sched_if #(
    parameter int ENTRIES       = 16,
    parameter int TIMECNT_WIDTH = 4
);
    localparam int IDX_W = $clog2(ENTRIES);
    logic [TIMECNT_WIDTH-1:0] cfg_threshold_i;
    logic                     cfg_reset_timecnt_on_write_i;
    logic                     alloc_i;
    logic [IDX_W-1:0]         alloc_idx_i;
    logic                     write_i;
    logic [IDX_W-1:0]         write_idx_i;
    logic                     close_i;
    logic [IDX_W-1:0]         close_idx_i;
    logic                     flush_all_i;
    logic                     send_valid_o;
    logic [IDX_W-1:0]         send_idx_o;
    logic                     send_ready_i;
    logic                     ack_i;
    logic [IDX_W-1:0]         ack_idx_i;
    logic [ENTRIES-1:0]       free_o;
    logic                     busy_o;
    modport master (
        output cfg_threshold_i, cfg_reset_timecnt_on_write_i, alloc_i, alloc_idx_i,
               write_i, write_idx_i, close_i, close_idx_i, flush_all_i,
               send_ready_i, ack_i, ack_idx_i,
        input  send_valid_o, send_idx_o, free_o, busy_o
    );
    modport slave (
        input  cfg_threshold_i, cfg_reset_timecnt_on_write_i, alloc_i, alloc_idx_i,
               write_i, write_idx_i, close_i, close_idx_i, flush_all_i,
               send_ready_i, ack_i, ack_idx_i,
        output send_valid_o, send_idx_o, free_o, busy_o
    );
endinterface

// File: rtl/hpdcache_wbuf_send_sched.sv
// hpdcache_wbuf_send_sched: per-entry FREE/OPEN/PEND/SENT tracking, OPEN-entry aging and round-robin send grant.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : cfg threshold/reset-on-write, alloc/write/close/flush commands,
//                  send_valid/send_idx/send_ready offer, ack, free/busy status
module hpdcache_wbuf_send_sched #(
    parameter int ENTRIES       = 16,
    parameter int TIMECNT_WIDTH = 4,
    parameter int IDX_W         = $clog2(ENTRIES)
) (
    input logic                         clk_i,
    input logic                         rst_i,
    hpdcache_wbuf_send_sched_if.slave   bus
);
    typedef enum logic [1:0] {FREE, OPEN, PEND, SENT} state_e;

    state_e                   r_state [ENTRIES];
    logic [TIMECNT_WIDTH-1:0] r_cnt   [ENTRIES];
    logic [IDX_W-1:0]         r_ptr, r_lock_idx;
    logic                     r_lock;
    logic [IDX_W-1:0]         w_rr_idx, w_send_idx;
    logic                     w_found, w_send_valid, w_hs;
    logic [ENTRIES-1:0]       w_pend, w_free, w_alloc, w_close, w_clr, w_ack;

    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            w_pend[e]  = r_state[e] == PEND;
            w_free[e]  = r_state[e] == FREE;
            w_alloc[e] = bus.alloc_i && bus.alloc_idx_i == IDX_W'(e);
            w_close[e] = bus.close_i && bus.close_idx_i == IDX_W'(e);
            w_clr[e]   = bus.write_i && bus.write_idx_i == IDX_W'(e) && bus.cfg_reset_timecnt_on_write_i;
            w_ack[e]   = bus.ack_i && bus.ack_idx_i == IDX_W'(e);
        end
    end

    // first PEND entry at or after the pointer, wrapping modulo ENTRIES
    always_comb begin
        logic [IDX_W-1:0] j;
        j        = '0;
        w_rr_idx = '0;
        w_found  = 1'b0;
        for (int k = 0; k < ENTRIES; k++) begin
            j = IDX_W'((int'(r_ptr) + k) % ENTRIES);
            if (!w_found && w_pend[j]) begin
                w_found  = 1'b1;
                w_rr_idx = j;
            end
        end
    end

    // a stalled offer is held so a newly PEND entry cannot steal it
    assign w_send_valid     = r_lock | (|w_pend);
    assign w_send_idx       = r_lock ? r_lock_idx : w_rr_idx;
    assign w_hs             = w_send_valid & bus.send_ready_i;
    assign bus.send_valid_o = w_send_valid;
    assign bus.send_idx_o   = w_send_idx;
    assign bus.free_o       = w_free;
    assign bus.busy_o       = ~&w_free;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int e = 0; e < ENTRIES; e++) begin
                r_state[e] <= FREE;
                r_cnt[e]   <= '0;
            end
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else begin
            for (int e = 0; e < ENTRIES; e++) begin
                case (r_state[e])
                    FREE: if (w_alloc[e]) begin
                        r_state[e] <= (w_close[e] | bus.flush_all_i) ? PEND : OPEN;
                        r_cnt[e]   <= '0;
                    end
                    OPEN: begin
                        r_cnt[e] <= w_clr[e] ? '0 : r_cnt[e] + TIMECNT_WIDTH'(~&r_cnt[e]);
                        if (w_close[e] | bus.flush_all_i | (!w_clr[e] && r_cnt[e] >= bus.cfg_threshold_i))
                            r_state[e] <= PEND;
                    end
                    PEND: if (w_hs && w_send_idx == IDX_W'(e)) r_state[e] <= SENT;
                    SENT: if (w_ack[e]) r_state[e] <= FREE;
                    default: ;
                endcase
            end
            if (w_hs) begin
                r_lock <= 1'b0;
                r_ptr  <= w_send_idx == IDX_W'(ENTRIES - 1) ? '0 : w_send_idx + IDX_W'(1);
            end else if (w_send_valid) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_send_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!bus.alloc_i || r_state[bus.alloc_idx_i] == FREE)
                else $error("alloc to non-free entry %0d", bus.alloc_idx_i);
            assert (!bus.ack_i || r_state[bus.ack_idx_i] == SENT)
                else $error("ack to non-sent entry %0d", bus.ack_idx_i);
        end
    end
endmodule

// File: doc/hpdcache_wbuf_send_sched.md
# hpdcache_wbuf_send_sched

Per-entry state and age scheduler for the HPDcache write-buffer directory. It tracks every directory entry through FREE/OPEN/PEND/SENT, ages OPEN entries with a saturating time counter, and closes them on a threshold, an explicit close or a flush. It then grants closed entries one at a time, round-robin, to the memory write-request port. It sits between the write-buffer directory/data arrays and the NoC send path; it holds no data.

## Interface
- `ENTRIES`, 16, number of write-buffer directory entries (≥2)
- `TIMECNT_WIDTH`, 4, width of the per-entry age counter
- `IDX_W`, $clog2(ENTRIES), entry index width (derived)

- `clk_i` in 1: clock
- `rst_i` in 1: reset, synchronous, active-high (one clock, synchronous active-high reset; no other clock or reset)
- `cfg_threshold_i` in TIMECNT_WIDTH: age at which an OPEN entry closes
- `cfg_reset_timecnt_on_write_i` in 1: a write to an OPEN entry clears its counter
- `alloc_i` / `alloc_idx_i` in 1 / IDX_W: allocate a FREE entry
- `write_i` / `write_idx_i` in 1 / IDX_W: merge write into an OPEN entry
- `close_i` / `close_idx_i` in 1 / IDX_W: force-close one entry
- `flush_all_i` in 1: close every OPEN entry
- `send_valid_o` out 1: a PEND entry is offered for sending
- `send_idx_o` out IDX_W: index of the offered entry
- `send_ready_i` in 1: send path accepts the offer
- `ack_i` / `ack_idx_i` in 1 / IDX_W: memory write acknowledged
- `free_o` out ENTRIES: bit i = entry i is FREE
- `busy_o` out 1: at least one entry is not FREE

## Operation
- Each entry has a state and a `cnt[TIMECNT_WIDTH]`. Reset puts all entries in FREE with cnt=0, the round-robin pointer at 0 and the lock clear. Reset values: `free_o` all ones, `busy_o`=0, `send_valid_o`=0, `send_idx_o`=0.
- FREE→OPEN on `alloc_i` at that index; cnt←0.
- OPEN:
  - cnt increments every cycle and saturates at all-ones.
  - `write_i` with `cfg_reset_timecnt_on_write_i`=1 sets cnt←0 that cycle instead of incrementing.
  - OPEN→PEND when any of these holds: `close_i` at that index; `flush_all_i`; or registered cnt ≥ `cfg_threshold_i` (unsigned) and no counter-clearing write that cycle.
  - Threshold 0 closes the entry the cycle after allocation.
- PEND→SENT on a send handshake (`send_valid_o & send_ready_i`) for that index.
- SENT→FREE on `ack_i` at that index.
- Same-cycle events:
  - `alloc_i` plus `close_i` or `flush_all_i` on the same index: FREE→PEND directly.
  - `write_i` plus `close_i` on the same index: the write is accepted and the entry goes PEND.
  - Alloc and ack on different indices are independent.
- Commands that do not match the entry state are ignored; no state change. This covers alloc to a non-FREE entry, write or close to a non-OPEN entry, and ack to a non-SENT entry. The simulation-only assertions fire on alloc to a non-FREE entry and on ack to a non-SENT entry.
- Arbitration:
  - `send_valid_o` = lock_q or any entry in PEND.
  - Unlocked: `send_idx_o` is the first PEND index at or after the pointer, searching upward modulo ENTRIES.
  - If valid and not ready, lock_q←1 and lock_idx_q←`send_idx_o`. While locked, `send_idx_o`=lock_idx_q; a new PEND entry cannot change the offer.
  - On handshake the lock clears and the pointer ← (idx+1) mod ENTRIES, wrapping at ENTRIES-1→0.
- `send_ready_i` is ignored while `send_valid_o`=0.
- `free_o` and `busy_o` decode the registered state.

## Timing
- All state is registered; `send_valid_o` and `send_idx_o` are combinational from registered state.
- Alloc at edge t: OPEN and cnt=0 at t+1.
- Threshold T with no writes: cnt=T at t+1+T, entry PEND and `send_valid_o`=1 at t+2+T.
- Handshake in cycle h: entry SENT at h+1; the next PEND entry is offered at h+1. This gives one send per cycle sustained.
- Ack in cycle a: `free_o` bit set at a+1.
- `flush_all_i` in cycle f: all OPEN entries are PEND at f+1.
- Reset asserted mid-handshake: `send_valid_o`=0 the cycle after the reset edge; an in-flight lock is discarded.

## Test plan
- Reset, then alloc idx 3 with threshold 4 and no writes → `send_valid_o` rises exactly 6 cycles after the alloc edge with `send_idx_o`=3. Ready=1 → SENT. Ack → `free_o[3]`=1 one cycle later.
- Threshold 4, reset-on-write=1, write idx 3 every 3 cycles for 20 cycles → never offered; offered 6 cycles after the last write.
- Entries 1, 5 and 14 PEND at once, pointer 0, ready always high → sends 1, 5, 14 on consecutive cycles; pointer=15. Then PEND 0 and 15 → 15 is sent before 0 (wrap).
- Offer idx 5 with ready low for 3 cycles while idx 2 becomes PEND → `send_idx_o` stays 5 until handshake; 2 is offered the next cycle.
- 4 OPEN entries and `flush_all_i` for 1 cycle → all PEND next cycle. Same-cycle alloc+close on idx 7 → PEND. Alloc to an OPEN idx → ignored and the assertion flags it.
- Assert `rst_i` while `send_valid_o`=1 and ready low → next cycle `send_valid_o`=0, `free_o` all ones, `busy_o`=0.
